// File: rtl/fw_wishbone_pkg.sv
// fw_wishbone_pkg: shared Wishbone slice FSM encodings and timeout counter sizing.
package fw_wishbone_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } slice_state_e;

  function automatic int ctr_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction
endpackage

// File: rtl/wb_slice_timeout_ctr.sv
// wb_slice_timeout_ctr: counts enabled cycles since clear, flags the LIMIT-th one.
module wb_slice_timeout_ctr
  import fw_wishbone_pkg::*;
#(
  parameter int LIMIT = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int CW = ctr_width(LIMIT);
  logic [CW-1:0] cnt;
  always_ff @(posedge clock)
    cnt <= (!reset || clear) ? '0 : en ? cnt + 1'b1 : cnt;
  assign expired = en && cnt == CW'(LIMIT - 1);
endmodule

// File: rtl/wb_initiator_slice.sv
// wb_initiator_slice: registered single-outstanding Wishbone classic bridge.
// Define WB_INITIATOR_SLICE_TIMEOUT_EN to terminate hung cycles with err after TIMEOUT_CYCLES.
module wb_initiator_slice
  import fw_wishbone_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WB_ADDR_WIDTH-1:0]   adr,
  input  logic [WB_DATA_WIDTH-1:0]   dat_w,
  output logic [WB_DATA_WIDTH-1:0]   dat_r,
  input  logic                       cyc,
  output logic                       err,
  input  logic [WB_DATA_WIDTH/8-1:0] sel,
  input  logic                       stb,
  output logic                       ack,
  input  logic                       we,
  output logic [WB_ADDR_WIDTH-1:0]   tadr,
  output logic [WB_DATA_WIDTH-1:0]   tdat_w,
  input  logic [WB_DATA_WIDTH-1:0]   tdat_r,
  output logic                       tcyc,
  input  logic                       terr,
  output logic [WB_DATA_WIDTH/8-1:0] tsel,
  output logic                       tstb,
  input  logic                       tack,
  output logic                       twe
);
  slice_state_e state;
  logic drop, tmo, done;
`ifdef WB_INITIATOR_SLICE_TIMEOUT_EN
  wb_slice_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_ctr (
    .clock  (clock),
    .reset  (reset),
    .clear  (state != REQ),
    .en     (state == REQ),
    .expired(tmo)
  );
`else
  assign tmo = TIMEOUT_CYCLES == 0;
`endif
  assign done = tack || terr || tmo;
  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      drop   <= 1'b0;
      ack    <= 1'b0;
      err    <= 1'b0;
      dat_r  <= '0;
      tadr   <= '0;
      tdat_w <= '0;
      tsel   <= '0;
      twe    <= 1'b0;
      tcyc   <= 1'b0;
      tstb   <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (cyc && stb) begin
          tadr   <= adr;
          tdat_w <= dat_w;
          tsel   <= sel;
          twe    <= we;
          tcyc   <= 1'b1;
          tstb   <= 1'b1;
          drop   <= 1'b0;
          state  <= REQ;
        end
        REQ: if (done) begin
          // a timeout without tack/terr reports err with zero data
          dat_r <= (terr || twe || !tack) ? '0 : tdat_r;
          ack   <= cyc && !drop && tack && !terr;
          err   <= cyc && !drop && (terr || !tack);
          tcyc  <= 1'b0;
          tstb  <= 1'b0;
          state <= RSP;
        end else if (!cyc) drop <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
